cram_read_arbiter: RTL and testbench

- Shares the single-beat CRAM AXI read channel (AR/R) between two requesters: instruction fetch (port f, driven by the instruction scheduler) and data load (port d, driven by the load/store unit).
- Round-robin arbitration with a registered AR stage.
- Per-requester outstanding-transaction limits, with R responses routed by ID.
- Fetch responses already in flight when a branch misprediction flushes the fetch stream are discarded.

---
 rtl/cram_read_arbiter_if.sv | 83 ++++++++
 rtl/cram_read_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_cram_read_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cram_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cram_read_arbiter_if
// Description : Signal bundle for the CRAM read arbiter. Holds the fetch
//               requester (f_*), the data requester (d_*), the flush strobe,
//               the shared single-beat AXI read channel (m_*) and the
//               performance counter outputs (perf_*).
//               modport master : arbiter view. It drives the AXI AR channel,
//                                m_rready, the requester grant/response
//                                signals and the perf counters.
//               modport slave  : environment view. It drives the requests,
//                                flush, m_arready and the R channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface cram_read_arbiter_if #(
    parameter int ADDR_W = 32
);
    // Fetch-stream flush (branch misprediction)
    logic              flush;

    // Fetch requester
    logic              f_arvalid;
    logic [ADDR_W-1:0] f_araddr;
    logic              f_arready;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic [1:0]        f_rresp;

    // Data requester
    logic              d_arvalid;
    logic [ADDR_W-1:0] d_araddr;
    logic              d_arready;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic [1:0]        d_rresp;

    // Shared AXI read channel
    logic [3:0]        m_arid;
    logic [ADDR_W-1:0] m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid;
    logic              m_arready;
    logic [3:0]        m_rid;
    logic [31:0]       m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;

    // Performance counters (tied to zero unless the feature is built in)
    logic [15:0]       perf_f_grants;
    logic [15:0]       perf_d_grants;
    logic [15:0]       perf_dropped;

    modport master (
        input  flush,
        input  f_arvalid, f_araddr,
        output f_arready, f_rvalid, f_rdata, f_rresp,
        input  d_arvalid, d_araddr,
        output d_arready, d_rvalid, d_rdata, d_rresp,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready,
        output perf_f_grants, perf_d_grants, perf_dropped
    );

    modport slave (
        output flush,
        output f_arvalid, f_araddr,
        input  f_arready, f_rvalid, f_rdata, f_rresp,
        output d_arvalid, d_araddr,
        input  d_arready, d_rvalid, d_rdata, d_rresp,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready,
        input  perf_f_grants, perf_d_grants, perf_dropped
    );
endinterface
`default_nettype wire

// File: rtl/cram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cram_read_arbiter
// Description : Shares the single-beat CRAM AXI read channel between the
//               instruction fetch requester (f) and the data load requester
//               (d). Round-robin grant into a registered AR holding stage,
//               per-requester outstanding limits, R routed by m_rid[0]
//               (0 = fetch, 1 = data). In-flight fetch reads at the time of a
//               flush have their responses discarded.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               bus  - cram_read_arbiter_if.master (requesters, flush,
//                      AXI AR/R channel, perf counters)
// Parameters  : MAX_OUTSTANDING - in-flight reads per requester (1..7)
//               ADDR_W          - address width (must match the interface)
// Options     : CRAM_ARB_PERF_EN - when defined, perf_f_grants,
//               perf_d_grants and perf_dropped count grants and dropped
//               fetch responses (16-bit saturating). Otherwise tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cram_read_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cram_read_arbiter_if.master bus
);

    // Counter width holds 0..MAX_OUTSTANDING inclusive.
    localparam int                 c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_ZERO  = '0;

    // Encoding of the last granted requester.
    localparam logic c_GNT_F = 1'b0;
    localparam logic c_GNT_D = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                arvalid_q,    arvalid_d;
    logic [ADDR_W-1:0]   araddr_q,     araddr_d;
    logic                arid_q,       arid_d;
    logic                last_grant_q, last_grant_d;
    logic [c_CNT_W-1:0]  cnt_f_q,      cnt_f_d;
    logic [c_CNT_W-1:0]  cnt_d_q,      cnt_d_d;
    logic [c_CNT_W-1:0]  drop_cnt_q,   drop_cnt_d;

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    logic w_hold_free;
    logic w_elig_f;
    logic w_elig_d;
    logic w_grant_f;
    logic w_grant_d;
    logic w_r_f;
    logic w_r_d;
    logic w_pass_f;
    logic w_drop_f;

    // Up/down counter: simultaneous increment and decrement cancel, and a
    // lone decrement saturates at zero so a stray response arriving after
    // a reset cannot wrap the count.
    function automatic logic [c_CNT_W-1:0] f_next_cnt(
        input logic [c_CNT_W-1:0] cnt,
        input logic               inc,
        input logic               dec
    );
        logic [c_CNT_W-1:0] r;
        r = cnt;
        if (inc && !dec) begin
            r = cnt + c_ONE;
        end else if (dec && !inc && (cnt != c_ZERO)) begin
            r = cnt - c_ONE;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        // HOLD can take a new request if empty, or if its current content
        // is being accepted by the slave in this same cycle.
        w_hold_free = !arvalid_q || bus.m_arready;

        // Grants are suppressed while in reset so a requester never sees
        // an acceptance that the reset is about to discard.
        w_elig_f = !rst && bus.f_arvalid && (cnt_f_q < c_MAX) &&
                   !bus.flush && w_hold_free;
        w_elig_d = !rst && bus.d_arvalid && (cnt_d_q < c_MAX) &&
                   w_hold_free;

        // Round robin: on contention the requester not granted last wins.
        w_grant_f = w_elig_f && (!w_elig_d || (last_grant_q == c_GNT_D));
        w_grant_d = w_elig_d && (!w_elig_f || (last_grant_q == c_GNT_F));
    end

    // ------------------------------------------------------------------
    // Response classification
    // ------------------------------------------------------------------
    always_comb begin
        w_r_f    = bus.m_rvalid && !bus.m_rid[0];
        w_r_d    = bus.m_rvalid &&  bus.m_rid[0];
        // A fetch response is forwarded only when nothing from before a
        // flush is still owed and no flush is happening right now.
        w_pass_f = w_r_f && (drop_cnt_q == c_ZERO) && !bus.flush;
        w_drop_f = w_r_f && !w_pass_f;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arid_d       = arid_q;
        last_grant_d = last_grant_q;

        if (w_grant_f || w_grant_d) begin
            arvalid_d    = 1'b1;
            araddr_d     = w_grant_d ? bus.d_araddr : bus.f_araddr;
            arid_d       = w_grant_d;
            last_grant_d = w_grant_d ? c_GNT_D : c_GNT_F;
        end else if (bus.m_arready) begin
            // Address and ID are left as they were; only valid drops.
            arvalid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_f_d = f_next_cnt(cnt_f_q, w_grant_f, w_r_f);
        cnt_d_d = f_next_cnt(cnt_d_q, w_grant_d, w_r_d);

        drop_cnt_d = drop_cnt_q;
        if (bus.flush) begin
            // Everything counted in cnt_f (including a fetch still sitting
            // in HOLD) becomes owed, less a fetch response consumed now.
            // No fetch grant can occur in a flush cycle, so cnt_f_q is the
            // full in-flight figure.
            if (w_r_f && (cnt_f_q != c_ZERO)) begin
                drop_cnt_d = cnt_f_q - c_ONE;
            end else if (w_r_f) begin
                drop_cnt_d = c_ZERO;
            end else begin
                drop_cnt_d = cnt_f_q;
            end
        end else if (w_r_f && (drop_cnt_q != c_ZERO)) begin
            drop_cnt_d = drop_cnt_q - c_ONE;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arid_q       <= 1'b0;
            last_grant_q <= c_GNT_D;  // fetch wins the first contention
            cnt_f_q      <= c_ZERO;
            cnt_d_q      <= c_ZERO;
            drop_cnt_q   <= c_ZERO;
        end else begin
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arid_q       <= arid_d;
            last_grant_q <= last_grant_d;
            cnt_f_q      <= cnt_f_d;
            cnt_d_q      <= cnt_d_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.f_arready = w_grant_f;
    assign bus.d_arready = w_grant_d;

    assign bus.m_arvalid = arvalid_q;
    assign bus.m_araddr  = araddr_q;
    assign bus.m_arid    = {3'b000, arid_q};
    assign bus.m_arlen   = 8'd0;
    assign bus.m_arsize  = 3'd2;
    assign bus.m_arburst = 2'd1;
    assign bus.m_rready  = 1'b1;

    assign bus.f_rvalid  = w_pass_f && !rst;
    assign bus.f_rdata   = bus.m_rdata;
    assign bus.f_rresp   = bus.m_rresp;
    assign bus.d_rvalid  = w_r_d && !rst;
    assign bus.d_rdata   = bus.m_rdata;
    assign bus.d_rresp   = bus.m_rresp;

    // Every read is a single beat, so rlast and the upper ID bits carry
    // no information here.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, bus.m_rlast, bus.m_rid[3:1]};

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef CRAM_ARB_PERF_EN
    logic [15:0] perf_f_q, perf_f_d;
    logic [15:0] perf_d_q, perf_d_d;
    logic [15:0] perf_x_q, perf_x_d;

    always_comb begin
        perf_f_d = perf_f_q;
        perf_d_d = perf_d_q;
        perf_x_d = perf_x_q;
        if (w_grant_f && (perf_f_q != 16'hFFFF)) perf_f_d = perf_f_q + 16'd1;
        if (w_grant_d && (perf_d_q != 16'hFFFF)) perf_d_d = perf_d_q + 16'd1;
        if (w_drop_f  && (perf_x_q != 16'hFFFF)) perf_x_d = perf_x_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_f_q <= 16'd0;
            perf_d_q <= 16'd0;
            perf_x_q <= 16'd0;
        end else begin
            perf_f_q <= perf_f_d;
            perf_d_q <= perf_d_d;
            perf_x_q <= perf_x_d;
        end
    end

    assign bus.perf_f_grants = perf_f_q;
    assign bus.perf_d_grants = perf_d_q;
    assign bus.perf_dropped  = perf_x_q;
`else
    logic w_unused_drop_ok;
    assign w_unused_drop_ok  = w_drop_f;
    assign bus.perf_f_grants = 16'd0;
    assign bus.perf_d_grants = 16'd0;
    assign bus.perf_dropped  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cram_read_arbiter
// Description : Self-checking bench for cram_read_arbiter. Directed scenario
//               tasks followed by a randomized run checked against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cram_read_arbiter;

    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cram_read_arbiter_if #(.ADDR_W(32)) bus();

    cram_read_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clr_in();
        bus.flush     = 1'b0;
        bus.f_arvalid = 1'b0;
        bus.f_araddr  = '0;
        bus.d_arvalid = 1'b0;
        bus.d_araddr  = '0;
        bus.m_arready = 1'b0;
        bus.m_rid     = 4'd0;
        bus.m_rdata   = 32'd0;
        bus.m_rresp   = 2'd0;
        bus.m_rlast   = 1'b1;
        bus.m_rvalid  = 1'b0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        clr_in();
        rst = 1'b1;
        bus.f_arvalid = 1'b1;
        bus.f_araddr  = 32'h40;
        tick();
        tick();
        sample();
        n_cmp++; if (bus.m_arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: got %0b want 0", bus.m_arvalid); end
        n_cmp++; if (bus.m_araddr !== 32'h0) begin n_err++; $display("FAIL rst_araddr: got %0h want 0", bus.m_araddr); end
        n_cmp++; if (bus.m_arid !== 4'h0) begin n_err++; $display("FAIL rst_arid: got %0h want 0", bus.m_arid); end
        n_cmp++; if (bus.f_arready !== 1'b0) begin n_err++; $display("FAIL rst_f_arready: got %0b want 0", bus.f_arready); end
        n_cmp++; if (bus.f_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got f=%0b d=%0b want 0", bus.f_rvalid, bus.d_rvalid); end
        n_cmp++; if (bus.m_arlen !== 8'd0 || bus.m_arsize !== 3'd2 || bus.m_arburst !== 2'd1 || bus.m_rready !== 1'b1)
            begin n_err++; $display("FAIL rst_consts: got len=%0d size=%0d burst=%0d rready=%0b want 0/2/1/1", bus.m_arlen, bus.m_arsize, bus.m_arburst, bus.m_rready); end
        n_cmp++; if (bus.perf_f_grants !== 16'd0 || bus.perf_d_grants !== 16'd0 || bus.perf_dropped !== 16'd0)
            begin n_err++; $display("FAIL rst_perf: got %0d/%0d/%0d want 0", bus.perf_f_grants, bus.perf_d_grants, bus.perf_dropped); end
        tick();
        clr_in();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_fetch();
        bus.f_arvalid = 1'b1; bus.f_araddr = 32'h100; bus.m_arready = 1'b1;
        sample();
        n_cmp++; if (bus.f_arready !== 1'b1) begin n_err++; $display("FAIL sf_arready: got %0b want 1", bus.f_arready); end
        n_cmp++; if (bus.m_arvalid !== 1'b0) begin n_err++; $display("FAIL sf_arvalid_c1: got %0b want 0", bus.m_arvalid); end
        tick();
        bus.f_arvalid = 1'b0;
        sample();
        n_cmp++; if (bus.m_arvalid !== 1'b1 || bus.m_araddr !== 32'h100 || bus.m_arid !== 4'd0)
            begin n_err++; $display("FAIL sf_ar: got v=%0b a=%0h id=%0h want 1/100/0", bus.m_arvalid, bus.m_araddr, bus.m_arid); end
        n_cmp++; if (bus.f_arready !== 1'b0) begin n_err++; $display("FAIL sf_arready_c2: got %0b want 0", bus.f_arready); end
        tick();
        bus.m_rvalid = 1'b1; bus.m_rid = 4'd0; bus.m_rdata = 32'hDEADBEEF; bus.m_rresp = 2'd0;
        sample();
        n_cmp++; if (bus.m_arvalid !== 1'b0) begin n_err++; $display("FAIL sf_arvalid_c3: got %0b want 0", bus.m_arvalid); end
        n_cmp++; if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 32'hDEADBEEF)
            begin n_err++; $display("FAIL sf_rdata: got v=%0b d=%0h want 1/deadbeef", bus.f_rvalid, bus.f_rdata); end
        n_cmp++; if (bus.d_rvalid !== 1'b0) begin n_err++; $display("FAIL sf_d_rvalid: got %0b want 0", bus.d_rvalid); end
        tick();
        bus.m_rvalid = 1'b0;
        sample();
        n_cmp++; if (bus.f_rvalid !== 1'b0) begin n_err++; $display("FAIL sf_rvalid_pulse: got %0b want 0", bus.f_rvalid); end
        tick();
    endtask

    // ------------------------------------------------------------------
    // Follows test_single_fetch without reset, so the grant total also
    // shows that cnt_f returned to 0.
    task automatic test_outstanding_limit();
        int grants;
        bus.f_arvalid = 1'b1; bus.f_araddr = 32'h300; bus.m_arready = 1'b0;
        sample();
        n_cmp++; if (bus.f_arready !== 1'b1) begin n_err++; $display("FAIL lim_first: got %0b want 1", bus.f_arready); end
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.f_araddr = 32'h300 + 32'(4 * (i + 1));
            sample();
            n_cmp++; if (bus.f_arready !== 1'b0) begin n_err++; $display("FAIL lim_stall_rdy[%0d]: got %0b want 0", i, bus.f_arready); end
            n_cmp++; if (bus.m_arvalid !== 1'b1 || bus.m_araddr !== 32'h300)
                begin n_err++; $display("FAIL lim_hold[%0d]: got v=%0b a=%0h want 1/300", i, bus.m_arvalid, bus.m_araddr); end
            tick();
        end
        bus.m_arready = 1'b1;
        grants = 1;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (bus.f_arready === 1'b1) grants++;
            tick();
        end
        n_cmp++; if (grants !== MAXO) begin n_err++; $display("FAIL lim_total: got %0d want %0d", grants, MAXO); end
        bus.d_arvalid = 1'b1; bus.d_araddr = 32'h900;
        sample();
        n_cmp++; if (bus.d_arready !== 1'b1 || bus.f_arready !== 1'b0)
            begin n_err++; $display("FAIL lim_d_grant: got d=%0b f=%0b want 1/0", bus.d_arready, bus.f_arready); end
        tick();
        clr_in();
    endtask

    // ------------------------------------------------------------------
    task automatic test_alternate();
        bus.f_arvalid = 1'b1; bus.f_araddr = 32'h1000;
        bus.d_arvalid = 1'b1; bus.d_araddr = 32'h2000;
        bus.m_arready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample();
            n_cmp++; if (bus.f_arready !== ((i % 2) == 0) || bus.d_arready !== ((i % 2) == 1))
                begin n_err++; $display("FAIL alt_grant[%0d]: got f=%0b d=%0b want f=%0b", i, bus.f_arready, bus.d_arready, (i % 2) == 0); end
            if (i > 0) begin
                n_cmp++; if (bus.m_arid !== 4'((i - 1) % 2))
                    begin n_err++; $display("FAIL alt_arid[%0d]: got %0h want %0h", i, bus.m_arid, (i - 1) % 2); end
            end
            tick();
        end
        clr_in();
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        bus.f_arvalid = 1'b1; bus.f_araddr = 32'h500; bus.m_arready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_cmp++; if (bus.f_arready !== 1'b1) begin n_err++; $display("FAIL fl_issue[%0d]: got %0b want 1", i, bus.f_arready); end
            tick();
        end
        bus.f_arvalid = 1'b0;
        tick();
        // flush coincides with the first response and a new fetch request
        bus.flush = 1'b1; bus.f_arvalid = 1'b1; bus.f_araddr = 32'h200;
        bus.m_rvalid = 1'b1; bus.m_rid = 4'd0; bus.m_rdata = 32'hA1;
        sample();
        n_cmp++; if (bus.f_rvalid !== 1'b0) begin n_err++; $display("FAIL fl_drop0: got %0b want 0", bus.f_rvalid); end
        n_cmp++; if (bus.f_arready !== 1'b0) begin n_err++; $display("FAIL fl_nogrant: got %0b want 0", bus.f_arready); end
        tick();
        bus.flush = 1'b0; bus.f_arvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.m_rdata = 32'hA2 + 32'(k);
            sample();
            n_cmp++; if (bus.f_rvalid !== 1'b0) begin n_err++; $display("FAIL fl_drop%0d: got %0b want 0", k + 1, bus.f_rvalid); end
            tick();
        end
        bus.m_rvalid = 1'b0; bus.f_arvalid = 1'b1; bus.f_araddr = 32'h200;
        sample();
        n_cmp++; if (bus.f_arready !== 1'b1) begin n_err++; $display("FAIL fl_new_grant: got %0b want 1", bus.f_arready); end
        tick();
        bus.f_arvalid = 1'b0;
        sample();
        n_cmp++; if (bus.m_arvalid !== 1'b1 || bus.m_araddr !== 32'h200 || bus.m_arid !== 4'd0)
            begin n_err++; $display("FAIL fl_new_ar: got v=%0b a=%0h id=%0h want 1/200/0", bus.m_arvalid, bus.m_araddr, bus.m_arid); end
        tick();
        bus.m_rvalid = 1'b1; bus.m_rid = 4'd0; bus.m_rdata = 32'h12345678;
        sample();
        n_cmp++; if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 32'h12345678)
            begin n_err++; $display("FAIL fl_new_resp: got v=%0b d=%0h want 1/12345678", bus.f_rvalid, bus.f_rdata); end
        tick();
        clr_in();
    endtask

    // ------------------------------------------------------------------
    task automatic test_interleave();
        bus.m_arready = 1'b1;
        bus.d_arvalid = 1'b1; bus.d_araddr = 32'h600;
        sample();
        n_cmp++; if (bus.d_arready !== 1'b1) begin n_err++; $display("FAIL il_d_grant: got %0b want 1", bus.d_arready); end
        tick();
        bus.d_arvalid = 1'b0; bus.f_arvalid = 1'b1; bus.f_araddr = 32'h700;
        sample();
        n_cmp++; if (bus.f_arready !== 1'b1) begin n_err++; $display("FAIL il_f_grant: got %0b want 1", bus.f_arready); end
        tick();
        bus.f_arvalid = 1'b0;
        tick();
        bus.m_rvalid = 1'b1; bus.m_rid = 4'd1; bus.m_rdata = 32'hD0D0; bus.m_rresp = 2'd2;
        sample();
        n_cmp++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hD0D0 || bus.d_rresp !== 2'd2 || bus.f_rvalid !== 1'b0)
            begin n_err++; $display("FAIL il_d_resp: got dv=%0b d=%0h r=%0d fv=%0b want 1/d0d0/2/0", bus.d_rvalid, bus.d_rdata, bus.d_rresp, bus.f_rvalid); end
        tick();
        bus.m_rid = 4'd0; bus.m_rdata = 32'hF0F0; bus.m_rresp = 2'd3;
        sample();
        n_cmp++; if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 32'hF0F0 || bus.f_rresp !== 2'd3 || bus.d_rvalid !== 1'b0)
            begin n_err++; $display("FAIL il_f_resp: got fv=%0b d=%0h r=%0d dv=%0b want 1/f0f0/3/0", bus.f_rvalid, bus.f_rdata, bus.f_rresp, bus.d_rvalid); end
        tick();
        clr_in();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        int grants;
        bus.m_arready = 1'b1; bus.d_arvalid = 1'b1; bus.d_araddr = 32'h800;
        for (int i = 0; i < 2; i++) begin
            sample();
            n_cmp++; if (bus.d_arready !== 1'b1) begin n_err++; $display("FAIL rm_issue[%0d]: got %0b want 1", i, bus.d_arready); end
            tick();
        end
        bus.d_arvalid = 1'b0;
        rst = 1'b1;
        tick();
        sample();
        n_cmp++; if (bus.m_arvalid !== 1'b0 || bus.m_araddr !== 32'h0 || bus.m_arid !== 4'd0)
            begin n_err++; $display("FAIL rm_ar: got v=%0b a=%0h id=%0h want 0/0/0", bus.m_arvalid, bus.m_araddr, bus.m_arid); end
        tick();
        rst = 1'b0;
        bus.m_rvalid = 1'b1; bus.m_rid = 4'd1; bus.m_rdata = 32'hBEEF;
        sample();
        n_cmp++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hBEEF)
            begin n_err++; $display("FAIL rm_late: got v=%0b d=%0h want 1/beef", bus.d_rvalid, bus.d_rdata); end
        tick();
        bus.m_rvalid = 1'b0; bus.d_arvalid = 1'b1;
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (bus.d_arready === 1'b1) grants++;
            tick();
        end
        n_cmp++; if (grants !== MAXO) begin n_err++; $display("FAIL rm_no_underflow: got %0d grants want %0d", grants, MAXO); end
        clr_in();
    endtask

    // ------------------------------------------------------------------
    // Randomized traffic against a transaction-level model: per-requester
    // in-flight totals, one-entry AR slot, debt of fetch responses owed to
    // a flush, and the requester that won last.
    task automatic test_random();
        int          mcnt_f, mcnt_d, mdrop;
        bit          mlast;               // 1 = data won last
        bit          mhold_v, mhold_id;
        logic [31:0] mhold_addr;
        int          mperf_f, mperf_d, mperf_x;
        bit          pend_q[$];
        bit          free, ef, ed, gf, gd, rf, rd, exp_fv;
        int          idx;

        do_reset();
        mcnt_f = 0; mcnt_d = 0; mdrop = 0; mlast = 1'b1;
        mhold_v = 1'b0; mhold_id = 1'b0; mhold_addr = '0;
        mperf_f = 0; mperf_d = 0; mperf_x = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.f_arvalid = 1'($urandom_range(0, 1));
            bus.f_araddr  = $urandom & 32'hFFFF_FFFC;
            bus.d_arvalid = 1'($urandom_range(0, 1));
            bus.d_araddr  = $urandom & 32'hFFFF_FFFC;
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.m_arready = ($urandom_range(0, 9) < 7);
            bus.m_rdata   = $urandom;
            bus.m_rresp   = 2'($urandom_range(0, 3));
            bus.m_rvalid  = 1'b0;
            bus.m_rid     = 4'd0;
            if (pend_q.size() > 0 && $urandom_range(0, 9) < 4) begin
                idx = $urandom_range(0, pend_q.size() - 1);
                bus.m_rid    = {3'b000, pend_q[idx]};
                bus.m_rvalid = 1'b1;
                pend_q.delete(idx);
            end
            sample();

            free = !mhold_v || bus.m_arready;
            ef = bus.f_arvalid && (mcnt_f < MAXO) && !bus.flush && free;
            ed = bus.d_arvalid && (mcnt_d < MAXO) && free;
            gf = ef && (!ed || mlast);
            gd = ed && !gf;
            rf = bus.m_rvalid && (bus.m_rid[0] == 1'b0);
            rd = bus.m_rvalid && (bus.m_rid[0] == 1'b1);
            exp_fv = rf && (mdrop == 0) && !bus.flush;

            n_cmp++; if (bus.f_arready !== gf || bus.d_arready !== gd)
                begin n_err++; $display("FAIL rnd_grant @%0d: got f=%0b d=%0b want f=%0b d=%0b", cyc, bus.f_arready, bus.d_arready, gf, gd); end
            n_cmp++; if (bus.m_arvalid !== mhold_v)
                begin n_err++; $display("FAIL rnd_arvalid @%0d: got %0b want %0b", cyc, bus.m_arvalid, mhold_v); end
            if (mhold_v) begin
                n_cmp++; if (bus.m_araddr !== mhold_addr || bus.m_arid !== {3'b000, mhold_id})
                    begin n_err++; $display("FAIL rnd_ar @%0d: got a=%0h id=%0h want a=%0h id=%0h", cyc, bus.m_araddr, bus.m_arid, mhold_addr, mhold_id); end
            end
            n_cmp++; if (bus.f_rvalid !== exp_fv || bus.d_rvalid !== rd)
                begin n_err++; $display("FAIL rnd_rvalid @%0d: got f=%0b d=%0b want f=%0b d=%0b", cyc, bus.f_rvalid, bus.d_rvalid, exp_fv, rd); end
            if (exp_fv) begin
                n_cmp++; if (bus.f_rdata !== bus.m_rdata || bus.f_rresp !== bus.m_rresp)
                    begin n_err++; $display("FAIL rnd_fdata @%0d: got %0h/%0d want %0h/%0d", cyc, bus.f_rdata, bus.f_rresp, bus.m_rdata, bus.m_rresp); end
            end
            if (rd) begin
                n_cmp++; if (bus.d_rdata !== bus.m_rdata || bus.d_rresp !== bus.m_rresp)
                    begin n_err++; $display("FAIL rnd_ddata @%0d: got %0h/%0d want %0h/%0d", cyc, bus.d_rdata, bus.d_rresp, bus.m_rdata, bus.m_rresp); end
            end

            // The slave accepts whatever the slot shows this cycle.
            if (mhold_v && bus.m_arready) pend_q.push_back(mhold_id);

            if (bus.flush) mdrop = (mcnt_f > 0 && rf) ? mcnt_f - 1 : (rf ? 0 : mcnt_f);
            else if (rf && mdrop > 0) mdrop--;
            if (rf && !exp_fv) mperf_x++;

            if (gf && !rf) mcnt_f++;
            else if (rf && !gf && mcnt_f > 0) mcnt_f--;
            if (gd && !rd) mcnt_d++;
            else if (rd && !gd && mcnt_d > 0) mcnt_d--;

            if (gf || gd) begin
                mhold_v = 1'b1; mhold_id = gd;
                mhold_addr = gd ? bus.d_araddr : bus.f_araddr;
                mlast = gd;
                if (gf) mperf_f++; else mperf_d++;
            end else if (bus.m_arready) begin
                mhold_v = 1'b0;
            end
            tick();
        end
        clr_in();
        sample();
`ifdef CRAM_ARB_PERF_EN
        n_cmp++; if (bus.perf_f_grants !== 16'(mperf_f) || bus.perf_d_grants !== 16'(mperf_d) || bus.perf_dropped !== 16'(mperf_x))
            begin n_err++; $display("FAIL rnd_perf: got %0d/%0d/%0d want %0d/%0d/%0d", bus.perf_f_grants, bus.perf_d_grants, bus.perf_dropped, mperf_f, mperf_d, mperf_x); end
`else
        n_cmp++; if (bus.perf_f_grants !== 16'd0 || bus.perf_d_grants !== 16'd0 || bus.perf_dropped !== 16'd0)
            begin n_err++; $display("FAIL rnd_perf_tied: got %0d/%0d/%0d want 0 (model %0d/%0d/%0d)", bus.perf_f_grants, bus.perf_d_grants, bus.perf_dropped, mperf_f, mperf_d, mperf_x); end
`endif
        tick();
    endtask

    // ------------------------------------------------------------------
    initial begin
        clr_in();
        test_reset();
        test_single_fetch();
        test_outstanding_limit();
        do_reset();
        test_alternate();
        do_reset();
        test_flush();
        test_interleave();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
